// File: rtl/automata_stage_pipe_if.sv
// automata_stage_pipe_if
//   Bundles the symbol stream, the monitor report lines and the statistics
//   readout of one automata pipeline stage.
//   slave  : the stage itself (consumes stream/reports, drives outputs)
//   master : the upstream cluster / readout side
//   Signals:
//     run, sym_reset, top_symbols      stream in
//     report_in, clear_stats           report lines and stats clear
//     out_symbols, out_reset           retimed stream out
//     sticky_reports, first_valid,
//     first_index, first_id,
//     hit_count, report_pulse          report statistics
interface automata_stage_pipe_if #(
  parameter int SYM_W       = 8,
  parameter int NUM_REPORTS = 36,
  parameter int IDX_W       = 32,
  parameter int CNT_W       = 16
);
  localparam int ID_W = (NUM_REPORTS > 1) ? $clog2(NUM_REPORTS) : 1;

  logic                   run;
  logic                   sym_reset;
  logic [SYM_W-1:0]       top_symbols;
  logic [NUM_REPORTS-1:0] report_in;
  logic                   clear_stats;

  logic [SYM_W-1:0]       out_symbols;
  logic                   out_reset;
  logic [NUM_REPORTS-1:0] sticky_reports;
  logic                   first_valid;
  logic [IDX_W-1:0]       first_index;
  logic [ID_W-1:0]        first_id;
  logic [CNT_W-1:0]       hit_count;
  logic                   report_pulse;

  modport slave (
    input  run, sym_reset, top_symbols, report_in, clear_stats,
    output out_symbols, out_reset, sticky_reports, first_valid,
           first_index, first_id, hit_count, report_pulse
  );

  modport master (
    output run, sym_reset, top_symbols, report_in, clear_stats,
    input  out_symbols, out_reset, sticky_reports, first_valid,
           first_index, first_id, hit_count, report_pulse
  );
endinterface

// File: rtl/automata_stage_pipe.sv
// automata_stage_pipe
//   Symbol pipeline stage for LTL monitor clusters. Retimes {sym_reset,
//   symbol} through STAGES run-gated registers and folds the monitor
//   report lines of this stage into readout statistics.
//   Ports:
//     clk    clock
//     reset  asynchronous active-low reset
//     bus    automata_stage_pipe_if.slave (stream in/out, reports, stats)
module automata_stage_pipe #(
  parameter int SYM_W       = 8,
  parameter int STAGES      = 1,
  parameter int NUM_REPORTS = 36,
  parameter int IDX_W       = 32,
  parameter int CNT_W       = 16
) (
  input logic                 clk,
  input logic                 reset,
  automata_stage_pipe_if.slave bus
);
  localparam int ID_W = (NUM_REPORTS > 1) ? $clog2(NUM_REPORTS) : 1;

  typedef struct packed {
    logic             rst;
    logic [SYM_W-1:0] sym;
  } stage_t;

  // ---------------------------------------------------------------------
  // Stream pipeline: pipe[0] is the input tap, pipe[STAGES] the output.
  // Every stage advances only on run, so a stalled stream holds in place.
  // ---------------------------------------------------------------------
  stage_t [STAGES:0] pipe;

  assign pipe[0] = {bus.sym_reset, bus.top_symbols};

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)       pipe[g+1] <= '0;
      else if (bus.run) pipe[g+1] <= pipe[g];
    end
  end

  assign bus.out_symbols = pipe[STAGES].sym;
  assign bus.out_reset   = pipe[STAGES].rst;

  // ---------------------------------------------------------------------
  // Symbol index. idx holds the index the next plain symbol will get; a
  // restart symbol is itself index 0, so the one after it is index 1.
  // ---------------------------------------------------------------------
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] cur_idx;

  assign cur_idx = bus.sym_reset ? '0 : idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       idx <= '0;
    else if (bus.run) idx <= cur_idx + IDX_W'(1);
  end

  // ---------------------------------------------------------------------
  // Report aggregation
  // ---------------------------------------------------------------------
  logic            any;
  logic            hit;
  logic            cnt_sat;
  logic [ID_W-1:0] low_id;

  assign any     = |bus.report_in;
  assign hit     = bus.run & any;
  assign cnt_sat = &bus.hit_count;

  // Lowest-numbered set report line; scanning downward lets the last
  // (lowest) match win.
  always_comb begin
    low_id = '0;
    for (int i = NUM_REPORTS - 1; i >= 0; i--)
      if (bus.report_in[i]) low_id = ID_W'(i);
  end

  // clear_stats beats a same-cycle report; the pulse is not part of the
  // statistics, so it still reflects that report.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.sticky_reports <= '0;
      bus.first_valid    <= 1'b0;
      bus.first_index    <= '0;
      bus.first_id       <= '0;
      bus.hit_count      <= '0;
    end else if (bus.clear_stats) begin
      bus.sticky_reports <= '0;
      bus.first_valid    <= 1'b0;
      bus.first_index    <= '0;
      bus.first_id       <= '0;
      bus.hit_count      <= '0;
    end else if (bus.run) begin
      bus.sticky_reports <= bus.sticky_reports | bus.report_in;
      if (any && !cnt_sat)
        bus.hit_count <= bus.hit_count + CNT_W'(1);
      if (any && !bus.first_valid) begin
        bus.first_valid <= 1'b1;
        bus.first_index <= cur_idx;
        bus.first_id    <= low_id;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) bus.report_pulse <= 1'b0;
    else        bus.report_pulse <= hit;
  end
endmodule

// File: tb/tb_automata_stage_pipe.sv
// tb_automata_stage_pipe
//   Directed bench for automata_stage_pipe with STAGES=3, CNT_W=4.
//   Stream symbols are pushed to a scoreboard queue when driven and popped
//   when the run edge that should expose them at out_symbols has passed.
//   Statistics are tracked by a small reference model plus directed checks.
module tb_automata_stage_pipe;
  localparam int SYM_W = 8;
  localparam int STAGES = 3;
  localparam int NR = 36;
  localparam int IDX_W = 32;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  automata_stage_pipe_if #(.SYM_W(SYM_W), .NUM_REPORTS(NR), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

  automata_stage_pipe #(.SYM_W(SYM_W), .STAGES(STAGES), .NUM_REPORTS(NR),
                        .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int passed = 0;
  int total  = 0;
  int pulses = 0;

  logic [SYM_W:0]   sb_q[$];
  logic [SYM_W:0]   exp_out;
  logic [NR-1:0]    m_sticky;
  logic             m_fv;
  logic [IDX_W-1:0] m_fi;
  logic [5:0]       m_fid;
  logic [CNT_W-1:0] m_cnt;
  logic             m_pulse;
  logic [IDX_W-1:0] m_idx;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Model state after a reset; the pipe refills from zero.
  task automatic model_reset();
    sb_q.delete();
    for (int i = 0; i < STAGES - 1; i++) sb_q.push_back('0);
    exp_out  = '0;
    m_sticky = '0; m_fv = 1'b0; m_fi = '0; m_fid = '0; m_cnt = '0;
    m_pulse  = 1'b0; m_idx = '0;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".sym"},    64'(bus.out_symbols),    64'(exp_out[SYM_W-1:0]));
    chk({tag, ".rst"},    64'(bus.out_reset),      64'(exp_out[SYM_W]));
    chk({tag, ".sticky"}, 64'(bus.sticky_reports), 64'(m_sticky));
    chk({tag, ".fv"},     64'(bus.first_valid),    64'(m_fv));
    chk({tag, ".fi"},     64'(bus.first_index),    64'(m_fi));
    chk({tag, ".fid"},    64'(bus.first_id),       64'(m_fid));
    chk({tag, ".cnt"},    64'(bus.hit_count),      64'(m_cnt));
    chk({tag, ".pulse"},  64'(bus.report_pulse),   64'(m_pulse));
  endtask

  // One clock: drive, update model, take edge, compare 1 time unit later.
  task automatic step(input string tag, input logic r, input logic sr,
                      input logic [SYM_W-1:0] s, input logic [NR-1:0] rep,
                      input logic clr);
    logic [IDX_W-1:0] cur;
    logic             any;
    int               lo;
    bus.run = r; bus.sym_reset = sr; bus.top_symbols = s;
    bus.report_in = rep; bus.clear_stats = clr;
    cur = sr ? '0 : m_idx;
    any = |rep;
    if (r) sb_q.push_back({sr, s});
    if (clr) begin
      m_sticky = '0; m_fv = 1'b0; m_fi = '0; m_fid = '0; m_cnt = '0;
    end else if (r) begin
      m_sticky = m_sticky | rep;
      if (any && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
      if (any && !m_fv) begin
        lo = 0;
        while (!rep[lo]) lo++;
        m_fv = 1'b1; m_fi = cur; m_fid = lo[5:0];
      end
    end
    if (r) m_idx = cur + 1;
    m_pulse = r & any;
    @(posedge clk); #1;
    if (r) exp_out = sb_q.pop_front();
    chk_all(tag);
    if (bus.report_pulse) pulses++;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.run = 0; bus.sym_reset = 0; bus.top_symbols = '0;
    bus.report_in = '0; bus.clear_stats = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    reset = 1'b1;

    // stream with latency check
    step("s11", 1, 0, 8'h11, '0, 0);
    step("s22", 1, 0, 8'h22, '0, 0);
    step("s33", 1, 0, 8'h33, '0, 0);
    chk("lat3", 64'(bus.out_symbols), 64'h11);
    step("s44", 1, 0, 8'h44, '0, 0);

    // run gating with reports asserted
    step("gate0", 0, 0, 8'hEE, {NR{1'b1}}, 0);
    step("gate1", 0, 1, 8'hEF, {NR{1'b1}}, 0);
    chk("gate.hold", 64'(bus.out_symbols), 64'h22);
    chk("gate.cnt", 64'(bus.hit_count), 64'h0);
    step("s55", 1, 0, 8'h55, '0, 0);
    step("s66", 1, 0, 8'h66, '0, 0);

    // first hit: restart at symbol 0, hit at index 7, second hit at 12
    pulses = 0;
    step("fh0", 1, 1, 8'h00, '0, 0);
    for (int i = 1; i <= 6; i++) step("fh", 1, 0, 8'(i), '0, 0);
    step("fh7", 1, 0, 8'h07, (36'd1 << 5) | (36'd1 << 9), 0);
    for (int i = 8; i <= 11; i++) step("fh", 1, 0, 8'(i), '0, 0);
    step("fh12", 1, 0, 8'h0C, 36'd1 << 2, 0);
    chk("fh.index", 64'(bus.first_index), 64'd7);
    chk("fh.id", 64'(bus.first_id), 64'd5);
    chk("fh.sticky", 64'(bus.sticky_reports), 64'h224);
    chk("fh.cnt", 64'(bus.hit_count), 64'd2);
    chk("fh.pulses", 64'(pulses), 64'd2);

    // restart must not clear statistics
    step("srkeep", 1, 1, 8'h99, '0, 0);
    chk("srkeep.fi", 64'(bus.first_index), 64'd7);

    // clear colliding with a report
    step("clr", 1, 0, 8'hC0, 36'h1, 1);
    chk("clr.fv", 64'(bus.first_valid), 64'd0);
    chk("clr.cnt", 64'(bus.hit_count), 64'd0);
    chk("clr.pulse", 64'(bus.report_pulse), 64'd1);

    // saturation of a 4-bit counter
    for (int i = 0; i < 20; i++)
      step("sat", 1, 0, 8'(8'h80 + i), (36'd1 << ((i * 7) % NR)) | (36'd1 << 35), 0);
    chk("sat.cnt", 64'(bus.hit_count), 64'd15);
    step("sat2", 1, 0, 8'hF1, 36'h8, 0);
    step("sat3", 1, 0, 8'hF2, 36'h8, 0);
    chk("sat.hold", 64'(bus.hit_count), 64'd15);

    // clear while stalled
    step("clridle", 0, 0, 8'h00, 36'hF, 1);
    chk("clridle.sticky", 64'(bus.sticky_reports), 64'd0);

    step("pre", 1, 0, 8'h3C, '0, 0);
    step("pre", 1, 0, 8'h3D, '0, 0);

    // async reset for a partial cycle, no clock edge in between
    #1 reset = 1'b0;
    #1;
    model_reset();
    chk_all("areset");
    #1 reset = 1'b1;
    step("post0", 1, 0, 8'hA5, 36'h10, 0);
    chk("post.fi", 64'(bus.first_index), 64'd0);
    chk("post.fid", 64'(bus.first_id), 64'd4);
    step("post1", 1, 0, 8'hA6, '0, 0);
    step("post2", 1, 0, 8'hA7, '0, 0);
    chk("post.lat", 64'(bus.out_symbols), 64'hA5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/automata_stage_pipe.md
Name: automata_stage_pipe

Overview:
- Parametrised symbol-pipeline stage for the LTL monitor clusters.
- Forwards the 8-bit-class symbol stream and the stream-restart flag through STAGES registers, advancing only on run, so that long cluster chains can be retimed.
- Aggregates the report outputs of all monitors in the stage into sticky flags, a first-hit record and a saturating hit counter, ready for the readout logic.

Parameters:
- SYM_W, 8, symbol width.
- STAGES, 1, symbol/reset pipeline depth (>=1).
- NUM_REPORTS, 36, total monitor report lines feeding the stage.
- IDX_W, 32, width of the symbol-index counter and captured index.
- CNT_W, 16, width of the saturating hit counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-low reset.
- run  in  1  stream advance enable; symbol consumed when 1.
- sym_reset  in  1  synchronous stream restart, sampled when run=1.
- top_symbols  in  SYM_W  incoming symbol.
- report_in  in  NUM_REPORTS  monitor reports for the symbol currently on top_symbols.
- clear_stats  in  1  synchronous clear of sticky, first-hit and counter state.
- out_symbols  out  SYM_W  symbol delayed STAGES run-cycles.
- out_reset  out  1  sym_reset delayed STAGES run-cycles.
- sticky_reports  out  NUM_REPORTS  OR of report_in since last clear.
- first_valid  out  1  a first hit has been captured.
- first_index  out  IDX_W  symbol index of first hit.
- first_id  out  $clog2(NUM_REPORTS)  lowest-numbered report set at first hit.
- hit_count  out  CNT_W  number of run-cycles with any report set, saturating.
- report_pulse  out  1  one-cycle pulse, registered, for every run-cycle with any report set.

Behaviour:
- Reset (reset=0, async):
  - All pipeline registers are 0, so out_symbols=0 and out_reset=0.
  - All statistics outputs are 0; symbol index is 0.
- Pipeline:
  - STAGES-deep shift of {sym_reset, top_symbols}; shifts only when run=1.
  - run=0 holds every stage, including out_reset.
  - Latency is exactly STAGES run-cycles.
- Symbol index counter idx:
  - Increments by 1 per run=1 cycle with sym_reset=0.
  - A run=1 cycle with sym_reset=1 sets idx to 0; the symbol presented in that cycle is index 0.
  - Wraps modulo 2^IDX_W.
- Report capture (only when run=1; report_in is ignored when run=0):
  - any = |report_in.
  - sticky_reports |= report_in.
  - If any and hit_count < 2^CNT_W-1, hit_count increments. At saturation it holds at all-ones.
  - report_pulse = any, registered one cycle later. It is 0 in cycles without run=1.
  - If any and first_valid=0: first_valid<=1, first_index<=idx value used for this symbol (0 if sym_reset=1 this cycle), first_id<=index of lowest set bit. Later hits never overwrite the record.
- sym_reset=1 with run=1 does not clear statistics. Only clear_stats or reset clear them.
- clear_stats=1:
  - Next edge sets sticky_reports, first_valid, first_index, first_id and hit_count to 0.
  - If a report arrives in the same cycle, clear has priority and that report is discarded (no pulse suppression: report_pulse still reflects it).
  - clear_stats acts independent of run.
- Mid-operation reset deassertion: the pipeline restarts empty. The first run cycle after reset is idx 0.

Test Plan:
- Reset then stream:
  - Stimulus: STAGES=3, feed symbols 0x11,0x22,0x33,0x44 with run=1.
  - Required: out_symbols=0x11 on the third edge after 0x11 is presented; out_reset=0 throughout.
- Run gating:
  - Stimulus: insert two run=0 cycles mid-stream, with report_in=all-ones during them.
  - Required: out_symbols holds, idx holds, hit_count unchanged, no report_pulse.
- First hit:
  - Stimulus: sym_reset at symbol 0, then report_in bits 5 and 9 at index 7, then bit 2 at index 12.
  - Required: first_index=7, first_id=5, sticky bits {2,5,9} set, hit_count=2, two report_pulses.
- Saturation:
  - Stimulus: CNT_W=4, 20 consecutive reporting symbols.
  - Required: hit_count=15 and stays 15.
- Clear vs report collision:
  - Stimulus: clear_stats together with report bit 0.
  - Required: statistics all 0 next cycle, first_valid=0, report_pulse=1.
- Async reset mid-stream:
  - Stimulus: drop reset for a partial cycle.
  - Required: outputs go to 0 immediately without a clock edge; after release, the first run symbol is index 0.
